// File: rtl/gsim_x_writer.sv
// Write-back stage for the Gauss-Seidel solver: buffers solved x elements,
// saturates them to 32 bits and writes them to x memory at {matrix, element}.
module gsim_x_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_module_en,
  input  logic [4:0]  i_matrix_num,
  input  logic        i_x_vld,
  input  logic [36:0] i_x_data,
  output logic        o_x_rdy,
  output logic        o_x_wen,
  output logic [8:0]  o_x_addr,
  output logic [31:0] o_x_data,
  output logic        o_proc_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic          r_en_d;
  logic [4:0]    r_num;
  logic [3:0]    r_elem_idx;
  logic [4:0]    r_matrix_idx;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [8:0]    r_acc_cnt;
  logic [36:0]   r_mem [FIFO_DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_last;
  logic [8:0]    w_total;
  logic [36:0]   w_head;
  logic [31:0]   w_sat;

  assign w_total = {r_num, 4'b0000};

  // Stop accepting once every element of the run is in hand, so nothing
  // beyond the last result is ever taken from the solver.
  assign o_x_rdy = (r_state == S_RUN) && (r_count < DEPTH_C) && (r_acc_cnt != w_total);
  assign w_push  = i_x_vld && o_x_rdy;
  assign w_pop   = (r_state == S_RUN) && (r_count != '0);
  assign w_last  = (r_elem_idx == 4'd15) && (r_matrix_idx == (r_num - 5'd1));
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_sat = w_head[31:0];
    if (!((&w_head[36:31]) || ~(|w_head[36:31]))) begin
      w_sat = w_head[36] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_x_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_en_d       <= 1'b0;
      r_num        <= '0;
      r_elem_idx   <= '0;
      r_matrix_idx <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_acc_cnt    <= '0;
      o_x_wen      <= 1'b0;
      o_x_addr     <= '0;
      o_x_data     <= '0;
      o_proc_done  <= 1'b0;
    end else begin
      r_en_d <= i_module_en;
      case (r_state)
        S_IDLE: begin
          o_x_wen     <= 1'b0;
          o_proc_done <= 1'b0;
          if (i_module_en && !r_en_d) begin
            r_num        <= i_matrix_num;
            r_elem_idx   <= '0;
            r_matrix_idx <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_acc_cnt    <= '0;
            r_state      <= (i_matrix_num == 5'd0) ? S_DONE : S_RUN;
          end
        end

        S_RUN: begin
          if (w_push) begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_acc_cnt <= r_acc_cnt + 9'd1;
          end
          if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
          end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
          end
          if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            o_x_wen    <= 1'b1;
            o_x_addr   <= {r_matrix_idx, r_elem_idx};
            o_x_data   <= w_sat;
            r_elem_idx <= r_elem_idx + 4'd1;
            if (r_elem_idx == 4'd15) begin
              r_matrix_idx <= r_matrix_idx + 5'd1;
            end
            if (w_last) begin
              r_state <= S_DONE;
            end
          end else begin
            o_x_wen <= 1'b0;
          end
        end

        S_DONE: begin
          o_x_wen <= 1'b0;
          // Done is shown for at least one cycle even if enable already fell.
          if (!i_module_en && o_proc_done) begin
            o_proc_done <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            o_proc_done <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
